// File: rtl/sample_capture_writer.sv
// sample_capture_writer: write-side controller for a circular sample buffer.
// It writes samples continuously once armed. On a trigger it records the
// trigger address, writes post_len more samples, then stops and flags done.
// Optional feature macro: LEVEL_TRIG_EN. It adds the trig_level input and an
// internal trigger on a rising level crossing.
module sample_capture_writer #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     arm,
  input  logic                     trig,
  input  logic [ADDRESS_WIDTH-1:0] post_len,
`ifdef LEVEL_TRIG_EN
  input  logic [DATA_WIDTH-1:0]    trig_level,
`endif
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [ADDRESS_WIDTH-1:0] trig_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [AW-1:0]   trig_addr_q, trig_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            level_hit;

`ifdef LEVEL_TRIG_EN
  logic [DW-1:0]   prev_q, prev_d;

  // Rising crossing: previous accepted sample below the level, current at or above it
  always_comb begin
    level_hit = (prev_q < trig_level) && (trig_level <= din);
  end

  // Previous en-qualified sample; cleared on arm so a fresh capture starts from 0
  always_comb begin
    prev_d = prev_q;
    if (arm) begin
      prev_d = '0;
    end else if (en) begin
      prev_d = din;
    end
  end

  // Previous-sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  // External trigger only
  always_comb begin
    level_hit = 1'b0;
  end
`endif

  // Next-state and write-command logic; arm overrides any sample strobe
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    trig_addr_d = trig_addr_q;

    if (arm) begin
      state_d = ST_ARMED;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ARMED: begin
          if (en) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = din;
            ptr_d     = ptr_q + AW'(1);
            if (trig || level_hit) begin
              trig_addr_d = ptr_q;
              cnt_d       = post_len;
              state_d     = (post_len == '0) ? ST_DONE : ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (en) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = din;
            ptr_d     = ptr_q + AW'(1);
            cnt_d     = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      trig_addr_q <= trig_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign trig_addr = trig_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sample_capture_writer.sv
// Bench for sample_capture_writer: directed stimulus, a behavioural model
// compared on every falling edge, and literal expectations per scenario.
// Define LEVEL_TRIG_EN to also exercise the level-crossing trigger.
module tb_sample_capture_writer;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, en, arm, trig;
  logic [DW-1:0] din;
  logic [AW-1:0] post_len;
  logic [DW-1:0] trig_level;
  logic          wr_en, busy, done;
  logic [AW-1:0] wr_addr, trig_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  // Write log seen on the RAM port
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  sample_capture_writer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm), .trig(trig),
    .post_len(post_len),
`ifdef LEVEL_TRIG_EN
    .trig_level(trig_level),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trig_addr(trig_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 pre-trigger, 2 post-trigger, 3 finished.
  // "left" counts post-trigger samples still to be written.
  int            m_mode = 0;
  int            m_ptr  = 0;
  int            m_left = 0;
  int            m_prev = 0;
  logic          e_wr_en = 0, e_busy = 0, e_done = 0;
  logic [AW-1:0] e_wr_addr = 0, e_trig_addr = 0;
  logic [DW-1:0] e_wr_data = 0;

  always @(posedge clk) begin
    bit fire;
    fire = trig;
`ifdef LEVEL_TRIG_EN
    if (m_prev < int'(trig_level) && int'(trig_level) <= int'(din)) fire = 1;
`endif
    e_wr_en = 0;
    if (rst) begin
      m_mode = 0; m_ptr = 0; m_left = 0; m_prev = 0;
      e_wr_addr = 0; e_wr_data = 0; e_trig_addr = 0;
    end else if (arm) begin
      m_mode = 1; m_ptr = 0; m_prev = 0;
    end else begin
      if (en && (m_mode == 1 || m_mode == 2)) begin
        e_wr_en   = 1;
        e_wr_addr = AW'(m_ptr);
        e_wr_data = din;
        if (m_mode == 1) begin
          if (fire) begin
            e_trig_addr = AW'(m_ptr);
            m_left = int'(post_len);
            m_mode = (m_left == 0) ? 3 : 2;
          end
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 3;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      if (en) m_prev = int'(din);
    end
    e_busy = (m_mode == 1 || m_mode == 2);
    e_done = (m_mode == 3);
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("wr_en",     32'(wr_en),     32'(e_wr_en));
    chk("wr_addr",   32'(wr_addr),   32'(e_wr_addr));
    chk("wr_data",   32'(wr_data),   32'(e_wr_data));
    chk("trig_addr", 32'(trig_addr), 32'(e_trig_addr));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("done",      32'(done),      32'(e_done));
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  // One clock cycle with the given strobes; returns 1 time unit after the edge
  task automatic cyc(input logic a, input logic e, input logic t, input logic [DW-1:0] d);
    arm = a; en = e; trig = t; din = d;
    @(posedge clk);
    #1;
    arm = 0; en = 0; trig = 0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    rst = 1; en = 0; arm = 0; trig = 0; din = 0; post_len = 0; trig_level = 0;

    // 1: reset, then strobes in IDLE write nothing
    repeat (3) cyc(0, 0, 0, 8'h00);
    rst = 0;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 8'hAA);
      chk("idle_no_write", 32'(wr_en), 0);
    end
    cyc(0, 0, 0, 8'h00);
    chk("idle_log_empty", 32'(log_addr.size()), 0);

    // 2: five pre-trigger samples, trigger on the sixth, post_len=3
    clear_log();
    post_len = 8'd3;
    cyc(1, 0, 0, 8'h00);
    chk("armed_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, DW'(8'h10 + i));
    cyc(0, 1, 1, 8'h15);
    chk("t2_trig_addr", 32'(trig_addr), 5);
    chk("t2_trig_write_addr", 32'(wr_addr), 5);
    for (int i = 6; i < 9; i++) cyc(0, 1, 0, DW'(8'h10 + i));
    chk("t2_last_addr", 32'(wr_addr), 8);
    chk("t2_last_en", 32'(wr_en), 1);
    chk("t2_done", 32'(done), 1);
    chk("t2_not_busy", 32'(busy), 0);
    cyc(0, 1, 0, 8'h99);
    chk("t2_no_write_done", 32'(wr_en), 0);
    chk("t2_addr_hold", 32'(wr_addr), 8);
    chk("t2_data_hold", 32'(wr_data), 32'h18);
    cyc(0, 0, 0, 8'h00);
    chk("t2_write_count", 32'(log_addr.size()), 9);
    for (int i = 0; i < 9 && i < log_addr.size(); i++) begin
      chk("t2_log_addr", 32'(log_addr[i]), 32'(i));
      chk("t2_log_data", 32'(log_data[i]), 32'(8'h10 + i));
    end

    // 3: 300 samples wrap the buffer, trigger on the last with post_len=0
    clear_log();
    post_len = 8'd0;
    cyc(1, 0, 0, 8'h00);
    for (int i = 1; i <= 300; i++) cyc(0, 1, (i == 300), DW'(i));
    chk("t3_trig_addr", 32'(trig_addr), 43);
    chk("t3_done", 32'(done), 1);
    chk("t3_last_data", 32'(wr_data), 44);
    repeat (3) cyc(0, 1, 0, 8'h55);
    chk("t3_write_count", 32'(log_addr.size()), 300);
    if (log_addr.size() >= 257) begin
      chk("t3_wrap_top", 32'(log_addr[255]), 255);
      chk("t3_wrap_zero", 32'(log_addr[256]), 0);
    end

    // 4: arm together with trig and en in ARMED
    post_len = 8'd5;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h01);
    cyc(0, 1, 0, 8'h02);
    chk("t4_pre_addr", 32'(wr_addr), 1);
    cyc(1, 1, 1, 8'h03);
    chk("t4_no_write", 32'(wr_en), 0);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_trig_addr_kept", 32'(trig_addr), 43);
    cyc(0, 1, 0, 8'h04);
    chk("t4_restart_addr", 32'(wr_addr), 0);
    chk("t4_restart_data", 32'(wr_data), 4);
    chk("t4_still_no_trig", 32'(trig_addr), 43);

    // 5: reset in the middle of a capture, then a clean restart
    post_len = 8'd10;
    cyc(0, 1, 1, 8'h05);
    chk("t5_trig_addr", 32'(trig_addr), 1);
    cyc(0, 1, 0, 8'h06);
    cyc(0, 1, 0, 8'h07);
    rst = 1;
    cyc(0, 1, 0, 8'h77);
    rst = 0;
    chk("t5_rst_wr_en", 32'(wr_en), 0);
    chk("t5_rst_addr", 32'(wr_addr), 0);
    chk("t5_rst_data", 32'(wr_data), 0);
    chk("t5_rst_trig", 32'(trig_addr), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    cyc(0, 1, 0, 8'h33);
    chk("t5_idle_no_write", 32'(wr_en), 0);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h42);
    chk("t5_restart_en", 32'(wr_en), 1);
    chk("t5_restart_addr", 32'(wr_addr), 0);
    chk("t5_restart_data", 32'(wr_data), 32'h42);

`ifdef LEVEL_TRIG_EN
    // 6: level crossing fires on the sample that reaches the level
    trig_level = 8'h80;
    post_len = 8'd1;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h70);
    cyc(0, 1, 0, 8'h78);
    chk("t6_no_early_trig", 32'(trig_addr), 0);
    cyc(0, 1, 0, 8'h80);
    chk("t6_trig_addr", 32'(trig_addr), 2);
    cyc(0, 1, 0, 8'h81);
    chk("t6_done", 32'(done), 1);
    trig_level = 8'h00;
`endif

    repeat (2) cyc(0, 0, 0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
